// File: rtl/dds_disp_pkg.sv
// Shared definitions for the DDS frequency readout: segment patterns,
// sequencer states and the digit-to-segment encoder.
package dds_disp_pkg;

    localparam int OP_W  = 10;
    localparam int BCD_W = 12;

    // gfedcba, active-low
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, CONV, UPD} state_t;

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bcd_shift3_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift
// the concatenated {bcd, operand} left by one bit.
module bcd_shift3_step
    import dds_disp_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    input  logic [OP_W-1:0]  op,
    output logic [BCD_W-1:0] bcd_nx,
    output logic [OP_W-1:0]  op_nx
);

    logic [BCD_W-1:0] adj;
    logic             unused_msb;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Top BCD bit can never be set for a 3-digit result; it falls off the shift.
    assign unused_msb      = adj[BCD_W-1];
    assign {bcd_nx, op_nx} = {adj[BCD_W-2:0], op, 1'b0};

endmodule

// File: rtl/freq_disp_ctrl.sv
// Frequency readout sequencer: scales the key word, converts it to BCD one
// bit per clock and updates the registered 7-segment digit outputs.
module freq_disp_ctrl
    import dds_disp_pkg::*;
#(
    parameter int KEY_W     = 9,
    parameter int DIV_SHIFT = 4,
    parameter int LZB       = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] keyin,
    input  logic             force_conv,
    output logic [6:0]       hundr,
    output logic [6:0]       dec,
    output logic [6:0]       uni,
    output logic [6:0]       ge,
    output logic             busy,
    output logic             upd
);

    localparam int CNT_W = $clog2(KEY_W + 1);
    // Operand is left-aligned so exactly KEY_W shifts move every value bit into the BCD field.
    localparam int ALIGN = OP_W - KEY_W;
    localparam logic [6:0] LEAD_RST = (LZB != 0) ? SEG_BLANK : SEG_0;

    state_t           state, state_nx;
    logic [KEY_W-1:0] shadow;
    logic [CNT_W-1:0] cnt;
    logic [OP_W-1:0]  op, op_nx;
    logic [BCD_W-1:0] bcd, bcd_nx;
    logic             trig, last;
    logic [3:0]       dig_h, dig_t, dig_u;
    logic             blank_h, blank_t;

    assign trig = (keyin != shadow) || force_conv;
    assign last = (cnt == CNT_W'(KEY_W - 1));
    assign busy = (state != IDLE);
    assign ge   = SEG_0;

    assign dig_h   = bcd[11:8];
    assign dig_t   = bcd[7:4];
    assign dig_u   = bcd[3:0];
    assign blank_h = (LZB != 0) && (dig_h == 4'd0);
    assign blank_t = blank_h && (dig_t == 4'd0);

    bcd_shift3_step u_step (
        .bcd    (bcd),
        .op     (op),
        .bcd_nx (bcd_nx),
        .op_nx  (op_nx)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (trig) state_nx = CONV;
            CONV:    if (last) state_nx = UPD;
            UPD:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Control and displayed outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            shadow <= '0;
            cnt    <= '0;
            upd    <= 1'b0;
            hundr  <= LEAD_RST;
            dec    <= LEAD_RST;
            uni    <= SEG_0;
        end else begin
            state <= state_nx;
            upd   <= (state == UPD);
            case (state)
                IDLE: begin
                    if (trig) begin
                        shadow <= keyin;
                        cnt    <= '0;
                    end
                end
                CONV: cnt <= cnt + 1'b1;
                UPD: begin
                    hundr <= blank_h ? SEG_BLANK : seg_encode(dig_h);
                    dec   <= blank_t ? SEG_BLANK : seg_encode(dig_t);
                    uni   <= seg_encode(dig_u);
                end
                default: ;
            endcase
        end
    end

    // Conversion datapath
    always_ff @(posedge clk) begin
        if (state == IDLE && trig) begin
            op  <= OP_W'(keyin >> DIV_SHIFT) << ALIGN;
            bcd <= '0;
        end else if (state == CONV) begin
            op  <= op_nx;
            bcd <= bcd_nx;
        end
    end

endmodule
